// File: rtl/hilo_muldiv_if.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_if
// Groups the decode-side request/read signals and the HI/LO unit responses.
//   master : the core datapath (drives op/operands/read request)
//   slave  : hilo_muldiv_unit (drives read data, HI/LO, busy, stall, flag)
// Signals:
//   op_valid, op[3:0], rs_val, rt_val : operation request and operands
//   rd_req, rd_sel                    : MFHI/MFLO request (rd_sel 1 = HI)
//   rd_data                           : selected register value
//   hi, lo                            : architectural HI/LO pair
//   busy, stall, div_by_zero          : divider status
// ---------------------------------------------------------------------------
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             rd_req;
    logic             rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             div_by_zero;

    modport master (
        output op_valid, op, rs_val, rt_val, rd_req, rd_sel,
        input  rd_data, hi, lo, busy, stall, div_by_zero
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, rd_req, rd_sel,
        output rd_data, hi, lo, busy, stall, div_by_zero
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
// HI/LO register stage behind the ALU. Holds the HI/LO pair, performs
// MULT/MULTU/MADD/MADDU/MSUB/MSUBU in one cycle, MTHI/MTLO moves, MFHI/MFLO
// reads, and DIV/DIVU as a WIDTH-iteration restoring divider that holds
// busy high (and so stalls the core) for WIDTH+1 cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (abandons an in-flight divide)
//   bus   : hilo_muldiv_if.slave (request, read and status signals)
// Optional build macro DIV_EARLY_OUT_EN: a divide whose divisor is zero or
// whose dividend magnitude is below the divisor magnitude skips the
// iterations and writes back one cycle after acceptance.
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    hilo_muldiv_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MADD  = 4'd3;
    localparam logic [3:0] OP_MADDU = 4'd4;
    localparam logic [3:0] OP_MSUB  = 4'd5;
    localparam logic [3:0] OP_MSUBU = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_DIV_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               dbz_r;

    // Divider working registers
    logic [WIDTH-1:0]   dvd_raw_r;   // dividend as presented, for divide-by-zero HI
    logic [WIDTH-1:0]   dvs_r;       // divisor magnitude
    logic [WIDTH-1:0]   rem_r;       // partial remainder
    logic [WIDTH-1:0]   quo_r;       // dividend bits shift out, quotient bits shift in
    logic               q_neg_r;
    logic               r_neg_r;
    logic               dvz_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               busy_s;
    logic               run_s;
    logic               wb_s;
    logic               accept_s;
    logic               div_start_s;
    logic               div_signed_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic               early_s;

    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     diff_s;
    logic               fits_s;
    logic [WIDTH-1:0]   q_res_s;
    logic [WIDTH-1:0]   r_res_s;
    logic [WIDTH-1:0]   div_hi_s;
    logic [WIDTH-1:0]   div_lo_s;

    logic               mul_signed_s;
    logic [2*WIDTH-1:0] mul_a_s;
    logic [2*WIDTH-1:0] mul_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] hilo_s;
    logic [2*WIDTH-1:0] mac_s;

    // ---------------- request decode ----------------
    assign accept_s     = bus.op_valid & ~busy_s;
    assign div_start_s  = accept_s & ((bus.op == OP_DIV) | (bus.op == OP_DIVU));
    assign div_signed_s = (bus.op == OP_DIV);

    // Operand magnitudes and result signs for the divider
    assign a_neg_s = div_signed_s & bus.rs_val[WIDTH-1];
    assign b_neg_s = div_signed_s & bus.rt_val[WIDTH-1];
    assign a_mag_s = a_neg_s ? ((~bus.rs_val) + ONE_W) : bus.rs_val;
    assign b_mag_s = b_neg_s ? ((~bus.rt_val) + ONE_W) : bus.rt_val;

`ifdef DIV_EARLY_OUT_EN
    // Quotient is zero (or the zero-divisor override applies): skip iterating
    assign early_s = (bus.rt_val == {WIDTH{1'b0}}) | (a_mag_s < b_mag_s);
`else
    assign early_s = 1'b0;
`endif

    // ---------------- FSM ----------------
    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (div_start_s) begin
                    state_nxt_s = early_s ? ST_DIV_DONE : ST_DIV_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIV_RUN: begin
                // cnt_r counts completed iterations; this edge performs the last one
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DIV_DONE;
                end else begin
                    state_nxt_s = ST_DIV_RUN;
                end
            end
            ST_DIV_DONE: state_nxt_s = ST_IDLE;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        busy_s = 1'b0;
        run_s  = 1'b0;
        wb_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_DIV_RUN: begin
                busy_s = 1'b1;
                run_s  = 1'b1;
            end
            ST_DIV_DONE: begin
                busy_s = 1'b1;
                wb_s   = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // ---------------- divider datapath ----------------
    // One restoring step: shift in next dividend bit, subtract if it fits
    assign rem_sh_s = {rem_r, quo_r[WIDTH-1]};
    assign diff_s   = rem_sh_s - {1'b0, dvs_r};
    assign fits_s   = ~diff_s[WIDTH];

    // Divider operand latch and iteration registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_raw_r <= {WIDTH{1'b0}};
            dvs_r     <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            dvz_r     <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else if (div_start_s) begin
            dvd_raw_r <= bus.rs_val;
            dvs_r     <= b_mag_s;
            q_neg_r   <= a_neg_s ^ b_neg_s;
            r_neg_r   <= a_neg_s;
            dvz_r     <= (bus.rt_val == {WIDTH{1'b0}});
            cnt_r     <= {CNT_W{1'b0}};
            if (early_s) begin
                rem_r <= a_mag_s;
                quo_r <= {WIDTH{1'b0}};
            end else begin
                rem_r <= {WIDTH{1'b0}};
                quo_r <= a_mag_s;
            end
        end else if (run_s) begin
            rem_r <= fits_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], fits_s};
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            rem_r <= rem_r;
            quo_r <= quo_r;
        end
    end

    // Signed result fix-up; most-negative / -1 falls out naturally as 0x80..0 rem 0
    always_comb begin
        q_res_s = q_neg_r ? ((~quo_r) + ONE_W) : quo_r;
        r_res_s = r_neg_r ? ((~rem_r) + ONE_W) : rem_r;
        if (dvz_r) begin
            div_lo_s = {WIDTH{1'b1}};
            div_hi_s = dvd_raw_r;
        end else begin
            div_lo_s = q_res_s;
            div_hi_s = r_res_s;
        end
    end

    // ---------------- multiply / accumulate ----------------
    assign mul_signed_s = (bus.op == OP_MULT) | (bus.op == OP_MADD) | (bus.op == OP_MSUB);
    assign mul_a_s = {{WIDTH{mul_signed_s & bus.rs_val[WIDTH-1]}}, bus.rs_val};
    assign mul_b_s = {{WIDTH{mul_signed_s & bus.rt_val[WIDTH-1]}}, bus.rt_val};
    // Sign-extended operands make a modulo-2^(2W) product equal the signed product
    assign prod_s  = mul_a_s * mul_b_s;
    assign hilo_s  = {hi_r, lo_r};

    // Select the new HI/LO pair for multiply-class operations
    always_comb begin
        mac_s = hilo_s;
        case (bus.op)
            OP_MULT, OP_MULTU: mac_s = prod_s;
            OP_MADD, OP_MADDU: mac_s = hilo_s + prod_s;
            OP_MSUB, OP_MSUBU: mac_s = hilo_s - prod_s;
            default:           mac_s = hilo_s;
        endcase
    end

    // ---------------- architectural HI/LO ----------------
    // HI/LO update: divide writeback or an accepted single-cycle op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (wb_s) begin
            hi_r <= div_hi_s;
            lo_r <= div_lo_s;
        end else if (accept_s) begin
            case (bus.op)
                OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                    hi_r <= mac_s[2*WIDTH-1:WIDTH];
                    lo_r <= mac_s[WIDTH-1:0];
                end
                OP_MTHI: hi_r <= bus.rs_val;
                OP_MTLO: lo_r <= bus.rs_val;
                default: begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            endcase
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Divide-by-zero pulse, visible the cycle after writeback
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbz_r <= 1'b0;
        end else begin
            dbz_r <= wb_s & dvz_r;
        end
    end

    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.busy        = busy_s;
    assign bus.stall       = busy_s & (bus.op_valid | bus.rd_req);
    assign bus.rd_data     = bus.rd_sel ? hi_r : lo_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_unit
// Directed scenarios plus randomized operations, each cycle compared against
// a behavioural HI/LO model (64-bit arithmetic, SV / and %, busy countdown).
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, MADD = 4'd3,
                           MADDU = 4'd4, MSUB = 4'd5, MSUBU = 4'd6, DIV = 4'd7,
                           DIVU = 4'd8, MTHI = 4'd9, MTLO = 4'd10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hilo_muldiv_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic        m_dbz = 1'b0;
    int          m_cnt = 0;
    logic [31:0] p_hi, p_lo;
    logic        p_dbz;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    function automatic logic [63:0] umul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y;
        x = {32'd0, a};
        y = {32'd0, b};
        return x * y;
    endfunction

    task automatic model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] am, bm;
        p_dbz = 1'b0;
        if (b == 32'd0) begin
            p_lo  = 32'hFFFFFFFF;
            p_hi  = a;
            p_dbz = 1'b1;
        end else if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            p_lo = 32'h80000000;
            p_hi = 32'd0;
        end else if (sgn) begin
            p_lo = $signed(a) / $signed(b);
            p_hi = $signed(a) % $signed(b);
        end else begin
            p_lo = a / b;
            p_hi = a % b;
        end
        am = (sgn && a[31]) ? -a : a;
        bm = (sgn && b[31]) ? -b : b;
        m_cnt = W + 1;
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'd0 || am < bm) m_cnt = 1;
`endif
    endtask

    // Apply one clock edge to the model using the inputs currently driven
    task automatic model_edge();
        logic [63:0] hl;
        hl = {m_hi, m_lo};
        if (!rst_n) begin
            m_hi = 32'd0; m_lo = 32'd0; m_cnt = 0; m_dbz = 1'b0;
        end else begin
            m_dbz = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
                end
            end else if (bus.op_valid) begin
                case (bus.op)
                    MULT:  {m_hi, m_lo} = smul(bus.rs_val, bus.rt_val);
                    MULTU: {m_hi, m_lo} = umul(bus.rs_val, bus.rt_val);
                    MADD:  {m_hi, m_lo} = hl + smul(bus.rs_val, bus.rt_val);
                    MADDU: {m_hi, m_lo} = hl + umul(bus.rs_val, bus.rt_val);
                    MSUB:  {m_hi, m_lo} = hl - smul(bus.rs_val, bus.rt_val);
                    MSUBU: {m_hi, m_lo} = hl - umul(bus.rs_val, bus.rt_val);
                    DIV:   model_div(1'b1, bus.rs_val, bus.rt_val);
                    DIVU:  model_div(1'b0, bus.rs_val, bus.rt_val);
                    MTHI:  m_hi = bus.rs_val;
                    MTLO:  m_lo = bus.rs_val;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic rq, input logic rsel);
        bus.op_valid = v;
        bus.op       = o;
        bus.rs_val   = a;
        bus.rt_val   = b;
        bus.rd_req   = rq;
        bus.rd_sel   = rsel;
    endtask

    // One cycle: check combinational outputs mid-cycle, registered ones after the edge
    task automatic cyc();
        @(negedge clk);
        check_val("stall", bus.stall, (m_cnt > 0) && (bus.op_valid || bus.rd_req));
        check_val("rd_data", bus.rd_data, bus.rd_sel ? m_hi : m_lo);
        @(posedge clk);
        model_edge();
        #1;
        check_val("hi", bus.hi, m_hi);
        check_val("lo", bus.lo, m_lo);
        check_val("busy", bus.busy, m_cnt > 0);
        check_val("div_by_zero", bus.div_by_zero, m_dbz);
    endtask

    task automatic run_div(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           output int n);
        drive(1'b1, o, a, b, 1'b0, 1'b0);
        cyc();
        drive(1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            cyc();
        end
        if (n >= 200) check_val("div_timeout", 64'(n), 64'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] rop;
        rst_n = 1'b0;
        drive(1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_hi", bus.hi, 32'd0);
        check_val("reset_lo", bus.lo, 32'd0);
        check_val("reset_busy", bus.busy, 1'b0);
        check_val("reset_dbz", bus.div_by_zero, 1'b0);
        rst_n = 1'b1;

        // Multiplies
        drive(1'b1, MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0); cyc();
        check_val("mult_hi", bus.hi, 32'hFFFFFFFF);
        check_val("mult_lo", bus.lo, 32'hFFFFFFFA);
        drive(1'b1, MULTU, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b1); cyc();
        check_val("multu_hi", bus.hi, 32'h00000002);
        check_val("multu_lo", bus.lo, 32'hFFFFFFFA);
        drive(1'b0, NOP, 32'd0, 32'd0, 1'b1, 1'b0); cyc();

        // Accumulate with carry/borrow across the LO/HI boundary
        drive(1'b1, MTLO, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0); cyc();
        drive(1'b1, MTHI, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
        drive(1'b1, MADDU, 32'd1, 32'd1, 1'b0, 1'b0); cyc();
        check_val("maddu_hi", bus.hi, 32'd1);
        check_val("maddu_lo", bus.lo, 32'd0);
        drive(1'b1, MSUBU, 32'd1, 32'd1, 1'b0, 1'b0); cyc();
        check_val("msubu_hi", bus.hi, 32'd0);
        check_val("msubu_lo", bus.lo, 32'hFFFFFFFF);

        // Divides
        run_div(DIV, 32'hFFFFFFF9, 32'd2, n);
        check_val("div_busy_cycles", 64'(n), 64'd33);
        check_val("div_lo", bus.lo, 32'hFFFFFFFD);
        check_val("div_hi", bus.hi, 32'hFFFFFFFF);
        run_div(DIVU, 32'd7, 32'd2, n);
        check_val("divu_lo", bus.lo, 32'd3);
        check_val("divu_hi", bus.hi, 32'd1);
        run_div(DIVU, 32'h1234, 32'd0, n);
        check_val("dz_lo", bus.lo, 32'hFFFFFFFF);
        check_val("dz_hi", bus.hi, 32'h1234);
        check_val("dz_flag", bus.div_by_zero, 1'b1);
        cyc();
        check_val("dz_flag_drop", bus.div_by_zero, 1'b0);
        run_div(DIV, 32'h80000000, 32'hFFFFFFFF, n);
        check_val("ovf_lo", bus.lo, 32'h80000000);
        check_val("ovf_hi", bus.hi, 32'd0);
        check_val("ovf_flag", bus.div_by_zero, 1'b0);

        // Small-dividend divide: early-out timing when enabled
        run_div(DIVU, 32'd3, 32'd5, n);
`ifdef DIV_EARLY_OUT_EN
        check_val("small_busy_cycles", 64'(n), 64'd1);
`else
        check_val("small_busy_cycles", 64'(n), 64'd33);
`endif
        check_val("small_lo", bus.lo, 32'd0);
        check_val("small_hi", bus.hi, 32'd3);
        run_div(DIV, 32'hFFFFFFFD, 32'd5, n);
        check_val("small_s_lo", bus.lo, 32'd0);
        check_val("small_s_hi", bus.hi, 32'hFFFFFFFD);

        // Requests held during a divide are stalled, MTLO lands after busy falls
        drive(1'b1, DIVU, 32'd100, 32'd7, 1'b0, 1'b0); cyc();
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            if (n < 8) drive(1'b0, NOP, 32'd0, 32'd0, 1'b1, 1'b1);
            else       drive(1'b1, MTLO, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);
            cyc();
        end
        check_val("hold_wb_lo", bus.lo, 32'd14);
        check_val("hold_wb_hi", bus.hi, 32'd2);
        cyc();
        check_val("hold_mtlo_lo", bus.lo, 32'hA5A5A5A5);
        check_val("hold_mtlo_hi", bus.hi, 32'd2);

        // Reset in the middle of a divide abandons it
        drive(1'b1, DIVU, 32'd1000, 32'd3, 1'b0, 1'b0); cyc();
        drive(1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) cyc();
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        check_val("mid_rst_busy", bus.busy, 1'b0);
        check_val("mid_rst_hi", bus.hi, 32'd0);
        check_val("mid_rst_lo", bus.lo, 32'd0);
        check_val("mid_rst_dbz", bus.div_by_zero, 1'b0);
        repeat (40) cyc();
        check_val("mid_rst_no_wb", bus.lo, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rop = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rop, rnd_operand(), rnd_operand(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
HI/LO register stage directly downstream of the ALU in the MIPS core.
- Holds the architectural HI/LO pair.
- Performs MULT/MADD/MSUB accumulation against the stored pair in one cycle.
- Runs DIV/DIVU as an iterative multi-cycle operation, raising a stall to the single-cycle datapath while busy.
- Serves MFHI/MFLO reads.

Parameters:
WIDTH, 32, operand and HI/LO register width; divider iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
op_valid  input  1  decoded HI/LO operation present this cycle
op  input  4  0 NOP, 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 DIV, 8 DIVU, 9 MTHI, 10 MTLO, 11-15 treated as NOP
rs_val  input  WIDTH  operand A (dividend / multiplicand / MT source)
rt_val  input  WIDTH  operand B (divisor / multiplier)
rd_req  input  1  MFHI/MFLO in this cycle
rd_sel  input  1  0 = LO, 1 = HI
rd_data  output  WIDTH  combinational: selected register value
hi  output  WIDTH  registered HI
lo  output  WIDTH  registered LO
busy  output  1  divider running (state != IDLE)
stall  output  1  combinational: busy & (op_valid | rd_req)
div_by_zero  output  1  one-cycle pulse on the edge a zero-divisor divide writes back

Behaviour:
Reset:
- Clock edge with rst_n=0 sets hi=0, lo=0, state=IDLE, iteration counter=0, div_by_zero=0.
- Applies mid-divide: the divide is abandoned and no writeback occurs.

Acceptance:
- An op is accepted on an edge where op_valid=1 and busy=0.
- While busy, op_valid and rd_req are ignored. stall stays high; the core holds the instruction until accepted.

Single-cycle ops (write at the acceptance edge, visible the next cycle):
- MULT: {hi,lo} = signed rs*rt (2*WIDTH product).
- MULTU: unsigned product.
- MADD/MADDU: {hi,lo} + product. MSUB/MSUBU: {hi,lo} - product.
  - 2*WIDTH arithmetic, wraps modulo 2^(2*WIDTH).
  - Signedness applies to the product only.
- MTHI: hi = rs_val, lo unchanged. MTLO: lo = rs_val, hi unchanged.
- NOP / unused codes: no state change.

Divide FSM (states IDLE -> DIV_RUN -> DIV_DONE -> IDLE):
- Acceptance edge E0 latches:
  - operand magnitudes (absolute values for DIV, raw for DIVU);
  - result signs;
  - divisor-zero flag.
  - Counter cleared; state = DIV_RUN.
- DIV_RUN: one restoring shift-subtract iteration per edge.
  - After WIDTH iterations (edge E0+WIDTH) go to DIV_DONE.
- DIV_DONE: edge E0+WIDTH+1 writes back and returns to IDLE.
  - lo = quotient, truncated toward zero.
  - hi = remainder, taking the dividend's sign.
- busy is high WIDTH+1 cycles. The next op can be accepted at E0+WIDTH+2.
- Divisor zero: same latency; lo = all ones, hi = rs_val as latched; div_by_zero=1 for the cycle following the writeback edge.
- Signed overflow (most negative value / -1): lo = 0x80000000, hi = 0; no flag.

Reads and timing:
- rd_data always reflects the registered hi/lo. A write is visible in the cycle after the edge that performs it.
- An MFLO/MFHI in the cycle after a single-cycle op therefore sees the new value.
- hi/lo are never modified during DIV_RUN; rd_data returns the pre-divide value, but stall masks any read.

Optional Feature:
Macro DIV_EARLY_OUT_EN.
- Defined: at acceptance, if the divisor is zero or |dividend| < |divisor| (unsigned compare for DIVU), the FSM goes straight to DIV_DONE.
  - Writeback at E0+1; busy high 1 cycle.
  - Results are identical to the full path (quotient 0, remainder = dividend for the small-dividend case).
- Undefined: every divide takes the full WIDTH+1 busy cycles.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- MTLO 0xFFFFFFFF, MTHI 0; MADDU 1*1 -> hi=1, lo=0; then MSUBU 1*1 -> hi=0, lo=0xFFFFFFFF.
- DIV rs=-7, rt=2 -> busy exactly 33 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU rs=7, rt=2 -> lo=3, hi=1.
- DIVU rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero pulse 1 cycle; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, no flag.
- During a divide, assert op_valid=MTLO and separately rd_req -> stall=1 each cycle, hi/lo unchanged until writeback; the MTLO takes effect only after busy falls.
- Assert rst_n=0 at divide iteration 10 -> next cycle busy=0, hi=lo=0, no div_by_zero; with DIV_EARLY_OUT_EN, DIVU 3/5 -> busy 1 cycle, lo=0, hi=3.
